// File: rtl/sv_alu_rp_pkg.sv
// Shared definitions for the ALU result packer: header layout, FSM states
// and the header word builder.
package sv_alu_rp_pkg;

  localparam logic [7:0] HDR_TAG = 8'hA5;

  localparam int HDR_TAG_MSB = 31;
  localparam int HDR_TAG_LSB = 24;
  localparam int HDR_CNT_MSB = 23;
  localparam int HDR_CNT_LSB = 16;
  localparam int HDR_SEQ_MSB = 15;
  localparam int HDR_SEQ_LSB = 0;

  localparam int TS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  function automatic logic [31:0] build_header(input logic [7:0] count,
                                               input logic [15:0] seq);
    logic [31:0] w;
    w = '0;
    w[HDR_TAG_MSB:HDR_TAG_LSB] = HDR_TAG;
    w[HDR_CNT_MSB:HDR_CNT_LSB] = count;
    w[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq;
    return w;
  endfunction

endpackage

// File: rtl/alu_rp_fifo.sv
// Single-clock result FIFO. A push and a pop in the same cycle are both
// honoured even when full: the freed head slot is the one being written.
module alu_rp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array, written on every accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/alu_result_packer.sv
// ALU result packer: buffers ALU results and emits them as headered frames
// on a valid/ready stream, with overflow flagging and an end-of-test flush.
// Optional build macro ALU_RESULT_PACKER_TIMESTAMP_EN tags each payload word
// with a 16-bit free-running cycle stamp in bits [31:16].
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a full frame or a flush; signals flush completion
// HEADER  | presenting the header word (tag, count, sequence)
// PAYLOAD | presenting FIFO head words until the latched count is sent
module alu_result_packer
  import sv_alu_rp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] EX_ALU,
  input  logic                  EX_ALU_VLD,
  input  logic                  FLUSH,
  output logic [OUT_WIDTH-1:0]  TX_DATA,
  output logic                  TX_SOF,
  output logic                  TX_EOF,
  output logic                  TX_VLD,
  input  logic                  TX_RDY,
  output logic                  FLUSH_DONE,
  output logic                  OVERFLOW
);

`ifdef ALU_RESULT_PACKER_TIMESTAMP_EN
  localparam int FW = TS_WIDTH + DATA_WIDTH;
`else
  localparam int FW = DATA_WIDTH;
`endif
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [7:0]    FRAME_LEN_N = 8'(FRAME_LEN);

  state_t          state;
  state_t          state_nx;
  logic [15:0]     seq;
  logic [7:0]      n_len;
  logic [7:0]      n_nx;
  logic [7:0]      remaining;
  logic            flush_pend;
  logic            done_set;
  logic            hdr_accept;
  logic            pop;
  logic            push;
  logic [FW-1:0]   fifo_din;
  logic [FW-1:0]   fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

`ifdef ALU_RESULT_PACKER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;

  // Free-running cycle stamp captured alongside each pushed result.
  always_ff @(posedge CLK) begin
    if (!RST) ts <= '0;
    else      ts <= ts + 1'b1;
  end

  assign fifo_din = {ts, EX_ALU};
`else
  assign fifo_din = EX_ALU;
`endif

  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push = EX_ALU_VLD && (!fifo_full || pop);

  alu_rp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state selection and stream outputs, all derived from registered state.
  always_comb begin
    state_nx   = state;
    n_nx       = n_len;
    done_set   = 1'b0;
    hdr_accept = 1'b0;
    pop        = 1'b0;
    TX_VLD     = 1'b0;
    TX_SOF     = 1'b0;
    TX_EOF     = 1'b0;
    TX_DATA    = '0;
    case (state)
      IDLE: begin
        if (fifo_count >= FRAME_LEN_C) begin
          n_nx     = FRAME_LEN_N;
          state_nx = HEADER;
        end else if (flush_pend && !fifo_empty) begin
          n_nx     = 8'(fifo_count);
          state_nx = HEADER;
        end else if (flush_pend) begin
          done_set = 1'b1;
        end
      end
      HEADER: begin
        TX_VLD  = 1'b1;
        TX_SOF  = 1'b1;
        TX_DATA = OUT_WIDTH'(build_header(n_len, seq));
        if (TX_RDY) begin
          hdr_accept = 1'b1;
          state_nx   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        TX_VLD = 1'b1;
        TX_EOF = (remaining == 8'd1);
`ifdef ALU_RESULT_PACKER_TIMESTAMP_EN
        TX_DATA = OUT_WIDTH'({fifo_dout[FW-1:DATA_WIDTH],
                              16'(fifo_dout[DATA_WIDTH-1:0])});
`else
        TX_DATA = OUT_WIDTH'(fifo_dout);
`endif
        if (TX_RDY) begin
          pop = 1'b1;
          if (remaining == 8'd1) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, frame bookkeeping, flush tracking and sticky overflow.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      seq        <= '0;
      n_len      <= '0;
      remaining  <= '0;
      flush_pend <= 1'b0;
      FLUSH_DONE <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      state      <= state_nx;
      n_len      <= n_nx;
      FLUSH_DONE <= done_set;
      if (done_set)   flush_pend <= 1'b0;
      else if (FLUSH) flush_pend <= 1'b1;
      if (EX_ALU_VLD && fifo_full && !pop) OVERFLOW <= 1'b1;
      if (hdr_accept) remaining <= n_len;
      else if (pop)   remaining <= remaining - 8'd1;
      if (pop && remaining == 8'd1) seq <= seq + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_packer.sv
// Self-checking bench for alu_result_packer: a queue-based model of the
// result stream checked every cycle, plus directed literal expectations.
module tb_alu_result_packer;

  localparam int DW    = 8;
  localparam int FL    = 4;
  localparam int DEPTH = 16;

`ifdef ALU_RESULT_PACKER_TIMESTAMP_EN
  localparam logic [31:0] PMASK = 32'h0000_FFFF;
`else
  localparam logic [31:0] PMASK = 32'hFFFF_FFFF;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] EX_ALU = '0;
  logic          EX_ALU_VLD = 1'b0;
  logic          FLUSH = 1'b0;
  logic          TX_RDY = 1'b0;
  logic [31:0]   TX_DATA;
  logic          TX_SOF, TX_EOF, TX_VLD, FLUSH_DONE, OVERFLOW;

  always #5 CLK = ~CLK;

  alu_result_packer #(
    .DATA_WIDTH (DW),
    .OUT_WIDTH  (32),
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EX_ALU     (EX_ALU),
    .EX_ALU_VLD (EX_ALU_VLD),
    .FLUSH      (FLUSH),
    .TX_DATA    (TX_DATA),
    .TX_SOF     (TX_SOF),
    .TX_EOF     (TX_EOF),
    .TX_VLD     (TX_VLD),
    .TX_RDY     (TX_RDY),
    .FLUSH_DONE (FLUSH_DONE),
    .OVERFLOW   (OVERFLOW)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: expected FIFO contents and stream bookkeeping.
  logic [31:0] mq[$];
  logic [33:0] obs[$];
  bit          exp_ovf = 0;
  logic [15:0] mseq = '0;
  logic [15:0] mts = '0;
  int          frame_left = 0;
  int          exp_n = 0;
  int          prev_occ = 0;
  bit          prev_flush = 0;
  bit          flush_active = 0;
  int          must_drain = 0;
  bit          stall_prev = 0;
  logic [31:0] prev_data = '0;
  logic        prev_sof = 0, prev_eof = 0;
  bit          rst_prev = 1;
  int          done_cnt = 0;

  // Compare DUT outputs with the model, then advance the model to the next edge.
  always @(negedge CLK) begin
    bit hs, pop, full;
    if (rst_prev) begin
      check("rst_tx_vld", 32'(TX_VLD), 32'd0);
      check("rst_tx_sof_eof", 32'({TX_SOF, TX_EOF}), 32'd0);
      check("rst_tx_data", TX_DATA, 32'd0);
      check("rst_flush_done", 32'(FLUSH_DONE), 32'd0);
      check("rst_overflow", 32'(OVERFLOW), 32'd0);
    end else begin
      check("overflow", 32'(OVERFLOW), 32'(exp_ovf));
      if (TX_VLD) begin
        if (stall_prev) begin
          check("stall_data", TX_DATA, prev_data);
          check("stall_sof_eof", 32'({TX_SOF, TX_EOF}), 32'({prev_sof, prev_eof}));
        end
        if (frame_left == 0) begin
          check("hdr_sof", 32'(TX_SOF), 32'd1);
          check("hdr_eof", 32'(TX_EOF), 32'd0);
          check("hdr_tag", 32'(TX_DATA[31:24]), 32'hA5);
          check("hdr_seq", 32'(TX_DATA[15:0]), 32'(mseq));
          if (!stall_prev) begin
            exp_n = (prev_occ < FL) ? prev_occ : FL;
            check("hdr_len", 32'(TX_DATA[23:16]), 32'(exp_n));
            if (prev_occ < FL) check("hdr_partial_flush", 32'(prev_flush), 32'd1);
          end
        end else begin
          check("pay_sof", 32'(TX_SOF), 32'd0);
          check("pay_eof", 32'(TX_EOF), 32'(frame_left == 1));
          if (mq.size() == 0) check("pay_avail", 32'(mq.size()), 32'd1);
          else                check("pay_data", TX_DATA, mq[0]);
        end
      end else begin
        check("vld_held", 32'(stall_prev), 32'd0);
      end
      if (FLUSH_DONE) begin
        check("done_pending", 32'(flush_active), 32'd1);
        check("done_drained", 32'(must_drain == 0 && frame_left == 0), 32'd1);
        done_cnt++;
        flush_active = 0;
      end
    end

    if (!RST) begin
      mq.delete();
      exp_ovf = 0; mseq = '0; mts = '0; frame_left = 0; prev_occ = 0;
      prev_flush = 0; flush_active = 0; must_drain = 0; stall_prev = 0;
      rst_prev = 1;
    end else begin
      rst_prev   = 0;
      prev_occ   = mq.size();
      prev_flush = flush_active;
      hs  = TX_VLD && TX_RDY;
      pop = hs && !TX_SOF;
      full = (mq.size() >= DEPTH);
      if (hs) obs.push_back({TX_SOF, TX_EOF, TX_DATA});
      if (hs && TX_SOF) frame_left = exp_n;
      if (pop) begin
        if (mq.size() > 0) void'(mq.pop_front());
        frame_left--;
        if (frame_left == 0) mseq = mseq + 16'd1;
        if (must_drain > 0) must_drain--;
      end
      if (EX_ALU_VLD) begin
        if (!full || pop) begin
`ifdef ALU_RESULT_PACKER_TIMESTAMP_EN
          mq.push_back({mts, 8'h00, EX_ALU});
`else
          mq.push_back(32'(EX_ALU));
`endif
        end else begin
          exp_ovf = 1;
        end
      end
      if (FLUSH && !flush_active) begin
        flush_active = 1;
        must_drain   = mq.size();
      end
      stall_prev = TX_VLD && !TX_RDY;
      prev_data  = TX_DATA;
      prev_sof   = TX_SOF;
      prev_eof   = TX_EOF;
      mts = mts + 16'd1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; EX_ALU_VLD = 1'b0; FLUSH = 1'b0;
    tick(); tick();
    RST = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    EX_ALU = v; EX_ALU_VLD = 1'b1;
    tick();
    EX_ALU_VLD = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int i = 0;
    while (obs.size() < n && i < budget) begin tick(); i++; end
    check(name, 32'(obs.size()), 32'(n));
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int i = 0;
    while (done_cnt == base && i < budget) begin tick(); i++; end
    check(name, 32'(done_cnt - base), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nh, np;
    #1;
    do_reset();

    // Full frame of 1..4, then a second frame with seq 1.
    TX_RDY = 1'b1;
    obs.delete();
    for (int i = 1; i <= 4; i++) begin
      EX_ALU = DW'(i); EX_ALU_VLD = 1'b1; tick();
    end
    EX_ALU_VLD = 1'b0;
    tick();
    check("hdr_latency", 32'({TX_VLD, TX_SOF}), 32'd3);
    wait_words(5, 50, "frame1_words");
    if (obs.size() >= 5) begin
      check("frame1_hdr", obs[0][31:0], 32'hA504_0000);
      for (int i = 1; i <= 4; i++) check("frame1_pay", obs[i][31:0] & PMASK, 32'(i));
      check("frame1_eof", 32'(obs[4][33:32]), 32'd1);
    end
    for (int i = 5; i <= 8; i++) send(DW'(i));
    wait_words(10, 50, "frame2_words");
    if (obs.size() >= 10) check("frame2_hdr", obs[5][31:0], 32'hA504_0001);

    // Partial frame on flush.
    do_reset();
    obs.delete();
    base = done_cnt;
    send(8'h10); send(8'h20);
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    wait_words(3, 50, "flush_words");
    if (obs.size() >= 3) begin
      check("flush_hdr", obs[0][31:0], 32'hA502_0000);
      check("flush_pay0", obs[1][31:0] & PMASK, 32'h10);
      check("flush_pay1", obs[2][31:0] & PMASK, 32'h20);
      check("flush_eof", 32'(obs[2][33:32]), 32'd1);
    end
    wait_done(base, 50, "flush_done_seen");

    // Flush with nothing buffered: done exactly two cycles after FLUSH.
    do_reset();
    obs.delete();
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    check("empty_flush_c1", 32'(FLUSH_DONE), 32'd0);
    tick();
    check("empty_flush_c2", 32'(FLUSH_DONE), 32'd1);
    tick();
    check("empty_flush_c3", 32'(FLUSH_DONE), 32'd0);
    check("empty_flush_noframe", 32'(obs.size()), 32'd0);

    // Overflow on the 17th result with the sink stalled.
    do_reset();
    TX_RDY = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'(8'h40 + i));
    check("ovf_before", 32'(OVERFLOW), 32'd0);
    send(8'h99);
    check("ovf_after", 32'(OVERFLOW), 32'd1);
    obs.delete();
    TX_RDY = 1'b1;
    repeat (60) tick();
    nh = 0; np = 0;
    foreach (obs[i]) if (obs[i][33]) nh++; else np++;
    check("ovf_drain_headers", 32'(nh), 32'd4);
    check("ovf_drain_payload", 32'(np), 32'd16);
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Toggling ready during frames.
    do_reset();
    obs.delete();
    TX_RDY = 1'b1;
    for (int i = 0; i < 40; i++) begin
      TX_RDY = ~TX_RDY;
      EX_ALU = DW'($urandom);
      EX_ALU_VLD = (i < 8);
      tick();
    end
    EX_ALU_VLD = 1'b0;
    TX_RDY = 1'b1;
    wait_words(10, 60, "toggle_words");

    // Reset in the middle of a payload.
    do_reset();
    TX_RDY = 1'b0;
    for (int i = 0; i < 17; i++) send(DW'(i));
    TX_RDY = 1'b1;
    tick(); tick();
    RST = 1'b0; tick();
    check("midrst_vld", 32'(TX_VLD), 32'd0);
    check("midrst_ovf", 32'(OVERFLOW), 32'd0);
    RST = 1'b1;
    obs.delete();
    for (int i = 0; i < 4; i++) send(DW'(8'hC0 + i));
    wait_words(5, 50, "midrst_words");
    if (obs.size() >= 5) check("midrst_hdr", obs[0][31:0], 32'hA504_0000);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      RST        = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      EX_ALU     = DW'($urandom);
      EX_ALU_VLD = ($urandom_range(0, 99) < 55);
      TX_RDY     = ($urandom_range(0, 99) < 70);
      FLUSH      = ($urandom_range(0, 99) < 2);
      tick();
    end
    RST = 1'b1; EX_ALU_VLD = 1'b0; FLUSH = 1'b0; TX_RDY = 1'b1;
    tick();
    base = done_cnt;
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    wait_done(base, 400, "final_flush_done");
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_packer.md
Name: alu_result_packer

Overview:
- Output-side hardware counterpart of the ALU stimulus path. Collects ALU results (EX_ALU/EX_ALU_VLD) in an FPGA verification build.
- Buffers results in a small FIFO and packs them into headered frames on a valid/ready stream toward the host-side scoreboard.
- The ALU cannot be back-pressured, so the block absorbs bursts and flags overflow.
- It also closes out a test run with a flush that emits a final partial frame.

Parameters:
- DATA_WIDTH, 8, ALU result width (must be <=16).
- OUT_WIDTH, 32, output stream word width (fixed 32 in this release).
- FRAME_LEN, 4, maximum payload words per frame (1..255).
- FIFO_DEPTH, 16, result FIFO depth (power of 2, >= FRAME_LEN).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low
- EX_ALU  in  DATA_WIDTH  ALU result
- EX_ALU_VLD  in  1  result valid, one result per cycle max
- FLUSH  in  1  single-cycle pulse: end of test, drain everything
- TX_DATA  out  32  frame word
- TX_SOF  out  1  first word of frame (header)
- TX_EOF  out  1  last word of frame
- TX_VLD  out  1  word valid
- TX_RDY  in  1  sink ready
- FLUSH_DONE  out  1  one-cycle pulse when flush completes
- OVERFLOW  out  1  sticky: a result was dropped

Behaviour:
- Reset (RST=0 at a rising edge):
  - All outputs go to 0.
  - FIFO is emptied, FSM goes to IDLE, sequence counter clears to 0, flush_pend clears.
  - Reset mid-frame aborts the frame with no EOF.
- FIFO push:
  - Occurs when EX_ALU_VLD=1 and (not full, or a pop happens in the same cycle).
  - Full with no same-cycle pop: the word is dropped and OVERFLOW is set to 1 until reset.
- Payload word format:
  - TX_DATA = result zero-extended to 32 bits.
- Header word format:
  - [31:24] = 8'hA5 tag.
  - [23:16] = payload count N.
  - [15:0] = frame sequence number.
- FSM states:
  - IDLE:
    - If fifo_count >= FRAME_LEN: latch N=FRAME_LEN and go to HEADER.
    - Else if flush_pend=1 and fifo_count>0: latch N=fifo_count and go to HEADER.
    - Else if flush_pend=1 and fifo_count=0: pulse FLUSH_DONE next cycle, clear flush_pend, stay in IDLE.
  - HEADER:
    - Drive TX_VLD=1, TX_SOF=1 with the header word.
    - On TX_RDY, go to PAYLOAD with remaining=N.
  - PAYLOAD:
    - Drive the FIFO head with TX_VLD=1.
    - On TX_RDY: pop the FIFO and decrement remaining.
    - When remaining=1, TX_EOF=1; the handshake on that word returns the FSM to IDLE and increments seq (wraps 16'hFFFF->0).
- Handshake rules:
  - Once TX_VLD=1, TX_DATA, TX_SOF and TX_EOF stay stable until TX_RDY=1.
  - TX_VLD never drops without a handshake.
  - TX_SOF and TX_EOF are both 1 only if N=1 was ever a header... this is not allowed: header and payload are always distinct words.
- Latency:
  - Earliest header is TX_VLD one cycle after the push that makes fifo_count reach FRAME_LEN.
  - Back-to-back frames: the next header may start the cycle after EOF is accepted.
- Flush rules:
  - FLUSH sets flush_pend. FLUSH while pend is already set is ignored.
  - Results arriving during a flush are included and are drained before FLUSH_DONE.
  - FLUSH with an empty FIFO and IDLE state gives FLUSH_DONE 2 cycles later and no frame.
- Payload pop with a simultaneous push: both take effect and the count is unchanged.

Optional Feature:
- Macro ALU_RESULT_PACKER_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter (reset 0, wraps) is captured with each pushed result.
  - Payload word = {timestamp[15:0], zero-extended result in [15:0]}.
  - FIFO width grows to 16+DATA_WIDTH.
- Undefined:
  - No counter exists.
  - Payload [31:DATA_WIDTH] = 0.
- Header format is identical in both builds.

Decomposition:
- Package sv_alu_rp_pkg holds:
  - The header tag constant 8'hA5.
  - The FSM state enum (IDLE, HEADER, PAYLOAD).
  - A header-building function (count, seq) -> 32-bit word.
  - Header field bit positions.
- Sub-module alu_rp_fifo:
  - Synchronous single-clock FIFO, parameterised width/depth.
  - Provides count, full, empty.
  - Push/pop in the same cycle is legal when full.

Test Plan:
- 4 results 8'h01..8'h04 on consecutive cycles, TX_RDY=1 -> header 32'hA504_0000, then 1,2,3,4 with EOF on 4; next frame header seq=1.
- 2 results 8'h10, 8'h20, then FLUSH -> header 32'hA502_0000, payload 0x10, 0x20 (EOF), then a FLUSH_DONE pulse.
- TX_RDY=0 while 17 results arrive (FIFO_DEPTH=16) -> OVERFLOW=1 from the 17th result onward; with TX_RDY then 1, exactly 16 results drain in 4 frames.
- TX_RDY toggling 1/0 every cycle during a frame -> TX_DATA stable during stalls, no word lost or duplicated.
- RST=0 asserted mid-PAYLOAD -> next cycle TX_VLD=0 and OVERFLOW=0; the next frame header has seq=0.
- With ALU_RESULT_PACKER_TIMESTAMP_EN, a result pushed at cycle 5 after reset release -> payload 32'h0005_00XX.
